// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared sizes and state encodings for the 16-way round-robin arbiter.
package rr_arb_pkg;
    localparam int N_REQ = 16;
    localparam int ID_W = 4;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;
endpackage

// File: rtl/rr_arbiter_16_if.sv
// rr_arbiter_16_if: request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_arbiter_16_if;
    logic [rr_arb_pkg::N_REQ-1:0] req;
    logic [rr_arb_pkg::N_REQ-1:0] gnt;
    logic gnt_valid;
    logic [rr_arb_pkg::ID_W-1:0] gnt_id;
    logic hold_expired;
    modport master (output req, input gnt, gnt_valid, gnt_id, hold_expired);
    modport slave (input req, output gnt, gnt_valid, gnt_id, hold_expired);
endinterface

// File: rtl/decoder_4_to_16.sv
// decoder_4_to_16: one-hot decode of a 4-bit index with active-low enable.
module decoder_4_to_16 (
    input logic [3:0] a,
    input logic en_n,
    output logic [15:0] y
);
    assign y = en_n ? 16'h0000 : 16'h0001 << a;
endmodule

// File: rtl/rr_pick_16.sv
// rr_pick_16: first unmasked request at or after ptr, wrapping modulo 16.
module rr_pick_16 import rr_arb_pkg::*; (
    input logic [N_REQ-1:0] req,
    input logic [ID_W-1:0] ptr,
    input logic [N_REQ-1:0] excl,
    output logic found,
    output logic [ID_W-1:0] id
);
    logic [N_REQ-1:0] cand;
    assign cand = req & ~excl;
    assign found = |cand;
    always_comb begin
        id = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (cand[ptr + ID_W'(i)]) id = ptr + ID_W'(i);
    end
endmodule

// File: rtl/rr_arbiter_16.sv
// rr_arbiter_16: 16-way round-robin arbiter with registered grant index and hold-limit rotation.
module rr_arbiter_16 import rr_arb_pkg::*; #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic reset,
    rr_arbiter_16_if.slave bus
);
    logic [0:0] state, state_n;
    logic [ID_W-1:0] ptr, ptr_n, gid, gid_n, pick_id;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [N_REQ-1:0] excl;
    logic found, own, last, exp_q, exp_n;
    assign own = bus.req[gid];
    assign last = cnt == CNT_W'(MAX_HOLD - 1);
    // The owner is masked so an expiry hands the grant to someone else.
    assign excl = (state == ST_GRANT) ? N_REQ'(1) << gid : '0;
    rr_pick_16 u_pick (.req(bus.req), .ptr(ptr), .excl(excl), .found(found), .id(pick_id));
    always_comb begin
        state_n = state;
        ptr_n = ptr;
        gid_n = gid;
        cnt_n = cnt;
        exp_n = 1'b0;
        if (state == ST_IDLE || !own || last) begin
            if (found) begin
                state_n = ST_GRANT;
                gid_n = pick_id;
                ptr_n = pick_id + 1'b1;
                cnt_n = '0;
                exp_n = (state == ST_GRANT) && own;
            end else if (state == ST_GRANT && !own) begin
                state_n = ST_IDLE;
                gid_n = '0;
                cnt_n = '0;
            end
        end else cnt_n = cnt + 1'b1;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= ST_IDLE;
            ptr <= '0;
            gid <= '0;
            cnt <= '0;
            exp_q <= 1'b0;
        end else begin
            state <= state_n;
            ptr <= ptr_n;
            gid <= gid_n;
            cnt <= cnt_n;
            exp_q <= exp_n;
        end
    decoder_4_to_16 u_dec (.a(gid), .en_n(~state[0]), .y(bus.gnt));
    assign bus.gnt_valid = state[0];
    assign bus.gnt_id = gid;
    assign bus.hold_expired = exp_q;
endmodule
